// File: rtl/memory_ctrl_fsm_if.sv
// Request/response bundle between the pin-side master and memory_ctrl_fsm.
// The master drives the request fields; the controller (slave) drives the response fields.
interface memory_ctrl_fsm_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
);
    localparam int unsigned ADDR_W = $clog2(DEPTH);

    logic              i_select;
    logic              i_operation;
    logic [ADDR_W-1:0] i_addr;
    logic [WIDTH-1:0]  i_wdata;
    logic              i_parity_inject;
    logic              o_ready;
    logic              o_done;
    logic [WIDTH-1:0]  o_rdata;
    logic              o_error;
    logic              o_parity_err;
    logic              o_operation;
    logic              o_select;

    modport master (
        output i_select, i_operation, i_addr, i_wdata, i_parity_inject,
        input  o_ready, o_done, o_rdata, o_error, o_parity_err, o_operation, o_select
    );

    modport slave (
        input  i_select, i_operation, i_addr, i_wdata, i_parity_inject,
        output o_ready, o_done, o_rdata, o_error, o_parity_err, o_operation, o_select
    );
endinterface

// File: rtl/memory_ctrl_fsm.sv
// WIDTH x DEPTH register-file memory sequenced by an IDLE/ACCESS/RESPOND handshake FSM.
// Define MEMCTRL_PARITY_EN to store a per-word even-parity bit and report read mismatches.
module memory_ctrl_fsm #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input logic              i_clock,
    input logic              i_reset,
    memory_ctrl_fsm_if.slave bus
);
    localparam int unsigned ADDR_W = $clog2(DEPTH);

    typedef enum logic [1:0] {StIdle, StAccess, StRespond} state_e;

    state_e            state_q, state_d;
    logic              op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [WIDTH-1:0]  wdata_q;
    logic [WIDTH-1:0]  rdata_q;
    logic              err_q;
    logic              perr_q;
    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic              accept;
    logic              in_range;

    assign accept   = (state_q == StIdle) && bus.i_select;
    assign in_range = (32'(addr_q) < DEPTH);

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:    if (bus.i_select) state_d = StAccess;
            StAccess:  state_d = StRespond;
            StRespond: state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_comb begin
        bus.o_ready     = (state_q == StIdle);
        bus.o_select    = (state_q != StIdle);
        bus.o_done      = (state_q == StRespond);
        bus.o_operation = (state_q != StIdle) && op_q;
        bus.o_error     = (state_q == StRespond) && err_q;
        bus.o_parity_err = (state_q == StRespond) && perr_q;
        bus.o_rdata     = rdata_q;
    end

    // Request fields are captured only at accept, so later pin activity is ignored.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            op_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (accept) begin
                op_q    <= bus.i_operation;
                addr_q  <= bus.i_addr;
                wdata_q <= bus.i_wdata;
            end
            if (state_q == StAccess) begin
                err_q <= !in_range;
                if (in_range) begin
                    if (op_q) begin
                        mem_q[addr_q] <= wdata_q;
                    end else begin
                        rdata_q <= mem_q[addr_q];
                    end
                end
            end
        end
    end

`ifdef MEMCTRL_PARITY_EN
    logic inject_q;
    logic par_q [DEPTH];

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            inject_q <= 1'b0;
            perr_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                par_q[i] <= 1'b0;
            end
        end else begin
            if (accept) begin
                inject_q <= bus.i_parity_inject;
            end
            if (state_q == StAccess) begin
                perr_q <= 1'b0;
                if (in_range) begin
                    if (op_q) begin
                        par_q[addr_q] <= (^wdata_q) ^ inject_q;
                    end else begin
                        perr_q <= (^mem_q[addr_q]) != par_q[addr_q];
                    end
                end
            end
        end
    end
`else
    logic unused_parity_inject;

    assign unused_parity_inject = bus.i_parity_inject;
    assign perr_q               = 1'b0;
`endif

endmodule

// File: tb/tb_memory_ctrl_fsm.sv
// Randomized self-checking bench for memory_ctrl_fsm (DEPTH=6 so addresses 6/7 are out of range).
// Expectations come from an array-based transaction model; MEMCTRL_PARITY_EN adds parity checks.
module tb_memory_ctrl_fsm;
    localparam int unsigned WIDTH  = 8;
    localparam int unsigned DEPTH  = 6;
    localparam int unsigned ADDR_W = $clog2(DEPTH);

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    memory_ctrl_fsm_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    memory_ctrl_fsm #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [WIDTH-1:0] mem_m [DEPTH];
    logic             bad_m [DEPTH];
    logic [WIDTH-1:0] rdata_m;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            mem_m[i] = '0;
            bad_m[i] = 1'b0;
        end
        rdata_m = '0;
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge after it is idle again.
    task automatic txn(input logic op, input logic [ADDR_W-1:0] addr,
                       input logic [WIDTH-1:0] wdata, input logic inj, input logic hold);
        int   a;
        int   waited;
        logic err;
        logic perr;
        a      = int'(addr);
        waited = 0;
        while (bus.o_ready !== 1'b1 && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        check_eq("ready_before_accept", 32'(bus.o_ready), 32'd1);
        bus.i_select        = 1'b1;
        bus.i_operation     = op;
        bus.i_addr          = addr;
        bus.i_wdata         = wdata;
        bus.i_parity_inject = inj;

        err  = (a >= int'(DEPTH));
        perr = 1'b0;
        if (!err) begin
            if (op) begin
                mem_m[a] = wdata;
                bad_m[a] = inj;
            end else begin
                rdata_m = mem_m[a];
                perr    = bad_m[a];
            end
        end
`ifndef MEMCTRL_PARITY_EN
        perr = 1'b0;
`endif

        @(negedge clk);
        bus.i_select        = hold;
        bus.i_operation     = 1'($urandom);
        bus.i_addr          = ADDR_W'($urandom);
        bus.i_wdata         = WIDTH'($urandom);
        bus.i_parity_inject = 1'($urandom);
        check_eq("access_ready", 32'(bus.o_ready), 32'd0);
        check_eq("access_select", 32'(bus.o_select), 32'd1);
        check_eq("access_operation", 32'(bus.o_operation), 32'(op));
        check_eq("access_done", 32'(bus.o_done), 32'd0);

        @(negedge clk);
        check_eq("respond_done", 32'(bus.o_done), 32'd1);
        check_eq("respond_ready", 32'(bus.o_ready), 32'd0);
        check_eq("respond_operation", 32'(bus.o_operation), 32'(op));
        check_eq("respond_error", 32'(bus.o_error), 32'(err));
        check_eq("respond_parity_err", 32'(bus.o_parity_err), 32'(perr));
        check_eq("respond_rdata", 32'(bus.o_rdata), 32'(rdata_m));

        @(negedge clk);
        check_eq("idle_done", 32'(bus.o_done), 32'd0);
        check_eq("idle_ready", 32'(bus.o_ready), 32'd1);
        check_eq("idle_select", 32'(bus.o_select), 32'd0);
        check_eq("idle_operation", 32'(bus.o_operation), 32'd0);
        check_eq("idle_rdata", 32'(bus.o_rdata), 32'(rdata_m));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic hold;
        bus.i_select        = 1'b0;
        bus.i_operation     = 1'b0;
        bus.i_addr          = '0;
        bus.i_wdata         = '0;
        bus.i_parity_inject = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_eq("reset_ready", 32'(bus.o_ready), 32'd1);
        check_eq("reset_done", 32'(bus.o_done), 32'd0);
        check_eq("reset_rdata", 32'(bus.o_rdata), 32'd0);
        check_eq("reset_select", 32'(bus.o_select), 32'd0);
        check_eq("reset_error", 32'(bus.o_error), 32'd0);
        check_eq("reset_operation", 32'(bus.o_operation), 32'd0);
        check_eq("reset_parity_err", 32'(bus.o_parity_err), 32'd0);

        txn(1'b0, 3'd3, 8'h77, 1'b0, 1'b0);
        txn(1'b1, 3'd5, 8'hA5, 1'b0, 1'b0);
        txn(1'b0, 3'd5, 8'h00, 1'b0, 1'b0);

        // Back-to-back sweep including the two out-of-range addresses.
        for (int k = 0; k < 8; k++) begin
            txn(1'b1, ADDR_W'(k), WIDTH'(8'h10 + k), 1'b0, 1'b1);
        end
        for (int k = 0; k < 8; k++) begin
            txn(1'b0, ADDR_W'(k), 8'h00, 1'b0, (k != 7));
        end

        txn(1'b1, 3'd6, 8'hFF, 1'b0, 1'b0);
        txn(1'b0, 3'd6, 8'h00, 1'b0, 1'b0);
        for (int k = 0; k < int'(DEPTH); k++) begin
            txn(1'b0, ADDR_W'(k), 8'h00, 1'b0, 1'b0);
        end

        // Reset lands on the ACCESS edge of a write.
        bus.i_select    = 1'b1;
        bus.i_operation = 1'b1;
        bus.i_addr      = 3'd2;
        bus.i_wdata     = 8'h3C;
        @(negedge clk);
        rst          = 1'b1;
        bus.i_select = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        check_eq("midreset_done", 32'(bus.o_done), 32'd0);
        check_eq("midreset_ready", 32'(bus.o_ready), 32'd1);
        check_eq("midreset_rdata", 32'(bus.o_rdata), 32'd0);
        @(negedge clk);
        check_eq("midreset_done_after", 32'(bus.o_done), 32'd0);
        txn(1'b0, 3'd2, 8'h00, 1'b0, 1'b0);

`ifdef MEMCTRL_PARITY_EN
        txn(1'b1, 3'd1, 8'h0F, 1'b1, 1'b0);
        txn(1'b0, 3'd1, 8'h00, 1'b0, 1'b0);
        txn(1'b1, 3'd1, 8'h0F, 1'b0, 1'b0);
        txn(1'b0, 3'd1, 8'h00, 1'b0, 1'b0);
`endif

        for (int i = 0; i < 150; i++) begin
            hold = (i != 149) && ($urandom_range(0, 1) == 1);
            txn(1'($urandom), ADDR_W'($urandom), WIDTH'($urandom),
                ($urandom_range(0, 3) == 0), hold);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
